// File: rtl/eth_axil_regs_pkg.sv
// Shared register map, response codes and channel FSM states for the Ethernet AXI4-Lite register file.
package eth_axil_regs_pkg;

   // Word index of each register (byte offset >> 2).
   localparam logic [2:0] IDX_CTRL    = 3'd0;
   localparam logic [2:0] IDX_STATUS  = 3'd1;
   localparam logic [2:0] IDX_TX      = 3'd2;
   localparam logic [2:0] IDX_RX      = 3'd3;
   localparam logic [2:0] IDX_SCRATCH = 3'd4;
   localparam logic [2:0] IDX_VERSION = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/eth_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS master port and the Ethernet register file.
interface eth_axil_regs_if #(parameter int ADDR_W = 8);
   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic              wvalid;
   logic              wready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              bvalid;
   logic [1:0]        bresp;
   logic              bready;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/eth_axil_regs.sv
// AXI4-Lite register file: CTRL/STATUS/SCRATCH/VERSION plus byte-wide TX/RX mailbox.
// Write commits on the edge AW and W are both available, B next cycle; read data 1 cycle after AR; one outstanding per channel.
module eth_axil_regs
   import eth_axil_regs_pkg::*;
#(
   parameter int          pAddr_Width = 8,
   parameter logic [31:0] pVersion    = 32'h0001_0000
) (
   input  logic           AXI_Clk,
   input  logic           AXI_Rstn,
   eth_axil_regs_if.slave axi,
   output logic [31:0]    Ctrl_Reg,
   input  logic [31:0]    Status_In,
   output logic [7:0]     Tx_Data,
   output logic           Tx_Data_Valid,
   input  logic [7:0]     Rx_Data,
   input  logic           Rx_Data_Valid
);

   w_state_t               w_state, w_state_nxt;
   r_state_t               r_state, r_state_nxt;
   logic                   aw_held, w_held;
   logic [pAddr_Width-1:0] aw_addr_q;
   logic [31:0]            w_data_q;
   logic [3:0]             w_strb_q;
   logic [31:0]            scratch;
   logic [7:0]             rx_byte;
   logic                   rx_full, rx_ovf, rd_is_rx;
   logic                   aw_fire, w_fire, commit, wr_ok;
   logic [pAddr_Width-1:0] wr_addr;
   logic [31:0]            wr_data;
   logic [3:0]             wr_strb;
   logic [2:0]             wr_idx, rd_idx;
   logic                   ar_fire, rx_clr, rd_ok;
   logic [31:0]            rd_data;
   logic                   unused_addr_bits;

   function automatic logic upper_clear(input logic [pAddr_Width-1:0] a);
      return a[pAddr_Width-1:5] == '0;
   endfunction

   // Readies are forced low while reset is asserted, not just after the reset edge.
   assign axi.awready = AXI_Rstn && (w_state == W_IDLE) && !aw_held;
   assign axi.wready  = AXI_Rstn && (w_state == W_IDLE) && !w_held;
   assign axi.bvalid  = (w_state == W_RESP);
   assign axi.arready = AXI_Rstn && (r_state == R_IDLE);
   assign axi.rvalid  = (r_state == R_DATA);

   assign aw_fire = axi.awvalid && axi.awready;
   assign w_fire  = axi.wvalid && axi.wready;
   assign wr_addr = aw_held ? aw_addr_q : axi.awaddr;
   assign wr_data = w_held ? w_data_q : axi.wdata;
   assign wr_strb = w_held ? w_strb_q : axi.wstrb;
   assign wr_idx  = wr_addr[4:2];
   assign commit  = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
   assign wr_ok   = upper_clear(wr_addr) &&
                    (wr_idx == IDX_CTRL || wr_idx == IDX_TX || wr_idx == IDX_SCRATCH);

   assign ar_fire = axi.arvalid && axi.arready;
   assign rd_idx  = axi.araddr[4:2];
   assign rx_clr  = axi.rvalid && axi.rready && rd_is_rx;

   assign unused_addr_bits = ^{wr_addr[1:0], axi.araddr[1:0]};

   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE: if (commit)     w_state_nxt = W_RESP;
         W_RESP: if (axi.bready) w_state_nxt = W_IDLE;
         default:                w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE: if (ar_fire)    r_state_nxt = R_DATA;
         R_DATA: if (axi.rready) r_state_nxt = R_IDLE;
         default:                r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      rd_data = '0;
      rd_ok   = upper_clear(axi.araddr);
      case (rd_idx)
         IDX_CTRL:    rd_data = Ctrl_Reg;
         IDX_STATUS:  rd_data = Status_In;
         IDX_TX:      rd_data = {24'b0, Tx_Data};
         IDX_RX:      rd_data = {22'b0, rx_ovf, rx_full, rx_byte};
         IDX_SCRATCH: rd_data = scratch;
         IDX_VERSION: rd_data = pVersion;
         default:     rd_ok   = 1'b0;
      endcase
      if (!rd_ok) rd_data = '0;
   end

   always_ff @(posedge AXI_Clk) begin
      if (!AXI_Rstn) begin
         w_state       <= W_IDLE;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_addr_q     <= '0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         axi.bresp     <= RESP_OKAY;
         Ctrl_Reg      <= '0;
         scratch       <= '0;
         Tx_Data       <= '0;
         Tx_Data_Valid <= 1'b0;
      end else begin
         w_state       <= w_state_nxt;
         Tx_Data_Valid <= 1'b0;
         if (commit) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            axi.bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
               case (wr_idx)
                  IDX_CTRL:    Ctrl_Reg <= apply_strb(Ctrl_Reg, wr_data, wr_strb);
                  IDX_SCRATCH: scratch  <= apply_strb(scratch, wr_data, wr_strb);
                  IDX_TX: if (wr_strb[0]) begin
                     Tx_Data       <= wr_data[7:0];
                     Tx_Data_Valid <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end else begin
            if (aw_fire) begin
               aw_held   <= 1'b1;
               aw_addr_q <= axi.awaddr;
            end
            if (w_fire) begin
               w_held   <= 1'b1;
               w_data_q <= axi.wdata;
               w_strb_q <= axi.wstrb;
            end
         end
      end
   end

   // Read data is a snapshot at AR accept; it stays frozen while rvalid waits on rready.
   always_ff @(posedge AXI_Clk) begin
      if (!AXI_Rstn) begin
         r_state   <= R_IDLE;
         axi.rdata <= '0;
         axi.rresp <= RESP_OKAY;
         rd_is_rx  <= 1'b0;
      end else begin
         r_state <= r_state_nxt;
         if (ar_fire) begin
            axi.rdata <= rd_data;
            axi.rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rd_is_rx  <= rd_ok && (rd_idx == IDX_RX);
         end
      end
   end

   // A byte arriving on the same edge as the clearing read survives with ovf cleared.
   always_ff @(posedge AXI_Clk) begin
      if (!AXI_Rstn) begin
         rx_byte <= '0;
         rx_full <= 1'b0;
         rx_ovf  <= 1'b0;
      end else if (Rx_Data_Valid) begin
         rx_byte <= Rx_Data;
         rx_full <= 1'b1;
         rx_ovf  <= !rx_clr && (rx_ovf || rx_full);
      end else if (rx_clr) begin
         rx_full <= 1'b0;
         rx_ovf  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_eth_axil_regs.sv
// Randomized bench for eth_axil_regs against a register-map level reference model.
module tb_eth_axil_regs;
   import eth_axil_regs_pkg::*;

   localparam logic [31:0] VERSION = 32'h0001_0000;

   logic        AXI_Clk = 1'b0;
   logic        AXI_Rstn = 1'b0;
   logic [31:0] Ctrl_Reg;
   logic [31:0] Status_In;
   logic [7:0]  Tx_Data;
   logic        Tx_Data_Valid;
   logic [7:0]  Rx_Data;
   logic        Rx_Data_Valid;

   always #5 AXI_Clk = ~AXI_Clk;

   eth_axil_regs_if #(.ADDR_W(8)) axi ();

   eth_axil_regs #(.pAddr_Width(8), .pVersion(VERSION)) dut (
      .AXI_Clk       (AXI_Clk),
      .AXI_Rstn      (AXI_Rstn),
      .axi           (axi),
      .Ctrl_Reg      (Ctrl_Reg),
      .Status_In     (Status_In),
      .Tx_Data       (Tx_Data),
      .Tx_Data_Valid (Tx_Data_Valid),
      .Rx_Data       (Rx_Data),
      .Rx_Data_Valid (Rx_Data_Valid)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_ctrl, m_scratch;
   logic [7:0]  m_tx, m_rx;
   logic        m_full, m_ovf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge AXI_Clk);
      #1;
   endtask

   function automatic void model_reset();
      m_ctrl = '0; m_scratch = '0; m_tx = '0; m_rx = '0; m_full = 1'b0; m_ovf = 1'b0;
   endfunction

   function automatic void model_rx(input logic [7:0] b);
      if (m_full) m_ovf = 1'b1;
      m_rx   = b;
      m_full = 1'b1;
   endfunction

   function automatic void model_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r);
      d = '0;
      r = RESP_OKAY;
      if (addr[7:5] != 3'b0) r = RESP_SLVERR;
      else case (addr & 8'h1C)
         8'h00: d = m_ctrl;
         8'h04: d = Status_In;
         8'h08: d = {24'b0, m_tx};
         8'h0C: d = {22'b0, m_ovf, m_full, m_rx};
         8'h10: d = m_scratch;
         8'h14: d = VERSION;
         default: r = RESP_SLVERR;
      endcase
   endfunction

   function automatic void model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                       output logic [1:0] r, output logic pulse);
      r     = RESP_SLVERR;
      pulse = 1'b0;
      if (addr[7:5] == 3'b0) begin
         case (addr & 8'h1C)
            8'h00: begin
               r = RESP_OKAY;
               for (int b = 0; b < 4; b++) if (strb[b]) m_ctrl[8*b +: 8] = data[8*b +: 8];
            end
            8'h10: begin
               r = RESP_OKAY;
               for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
            end
            8'h08: begin
               r = RESP_OKAY;
               if (strb[0]) begin m_tx = data[7:0]; pulse = 1'b1; end
            end
            default: ;
         endcase
      end
   endfunction

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output logic txv0, output logic txv1);
      int cyc = 0;
      logic aw_done = 1'b0, w_done = 1'b0, a_hs, w_hs;
      logic [1:0] resp0;
      axi.awaddr = addr;
      axi.wdata  = data;
      axi.wstrb  = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         axi.awvalid = !aw_done && (cyc >= aw_dly);
         axi.wvalid  = !w_done && (cyc >= w_dly);
         a_hs = axi.awvalid && axi.awready;
         w_hs = axi.wvalid && axi.wready;
         tick();
         if (a_hs) aw_done = 1'b1;
         if (w_hs) w_done = 1'b1;
         cyc++;
      end
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      check("wr_accept", 32'({aw_done, w_done}), 32'h3);
      txv0  = Tx_Data_Valid;
      txv1  = 1'b0;
      resp0 = axi.bresp;
      check("bvalid_after_commit", 32'(axi.bvalid), 32'd1);
      for (int i = 0; i < b_dly; i++) begin
         tick();
         if (i == 0) txv1 = Tx_Data_Valid;
         check("bvalid_hold", 32'(axi.bvalid), 32'd1);
         check("bresp_stable", 32'(axi.bresp), 32'(resp0));
         check("awready_blocked", 32'(axi.awready), 32'd0);
      end
      axi.bready = 1'b1;
      resp = axi.bresp;
      tick();
      axi.bready = 1'b0;
      if (b_dly == 0) txv1 = Tx_Data_Valid;
      check("bvalid_cleared", 32'(axi.bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int r_dly, input logic rx_inj, input logic [7:0] rx_b,
                           output logic [31:0] d, output logic [1:0] r);
      int cyc = 0;
      logic [31:0] d0;
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      while (!axi.arready && cyc < 20) begin tick(); cyc++; end
      check("ar_accept", 32'(axi.arready), 32'd1);
      tick();
      axi.arvalid = 1'b0;
      check("rvalid_latency", 32'(axi.rvalid), 32'd1);
      d0 = axi.rdata;
      for (int i = 0; i < r_dly; i++) begin
         tick();
         check("rvalid_hold", 32'(axi.rvalid), 32'd1);
         check("rdata_stable", axi.rdata, d0);
      end
      axi.rready = 1'b1;
      if (rx_inj) begin Rx_Data = rx_b; Rx_Data_Valid = 1'b1; end
      d = axi.rdata;
      r = axi.rresp;
      tick();
      axi.rready    = 1'b0;
      Rx_Data_Valid = 1'b0;
      check("rvalid_cleared", 32'(axi.rvalid), 32'd0);
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
      logic [1:0] exp_resp;
      logic exp_pulse, txv0, txv1;
      model_write(addr, data, strb, exp_resp, exp_pulse);
      axi_write(addr, data, strb, aw_dly, w_dly, b_dly, resp, txv0, txv1);
      check("bresp", 32'(resp), 32'(exp_resp));
      check("tx_pulse", 32'(txv0), 32'(exp_pulse));
      check("tx_pulse_end", 32'(txv1), 32'd0);
      check("ctrl_reg", Ctrl_Reg, m_ctrl);
      check("tx_data", 32'(Tx_Data), 32'(m_tx));
   endtask

   task automatic do_read(input logic [7:0] addr, input int r_dly, input logic rx_inj, input logic [7:0] rx_b,
                          output logic [31:0] d, output logic [1:0] r);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      model_read(addr, exp_d, exp_r);
      axi_read(addr, r_dly, rx_inj, rx_b, d, r);
      check("rdata", d, exp_d);
      check("rresp", 32'(r), 32'(exp_r));
      if (exp_r == RESP_OKAY && (addr & 8'h1C) == 8'h0C) begin m_full = 1'b0; m_ovf = 1'b0; end
      if (rx_inj) model_rx(rx_b);
   endtask

   task automatic rx_strobe(input logic [7:0] b);
      Rx_Data = b;
      Rx_Data_Valid = 1'b1;
      tick();
      Rx_Data_Valid = 1'b0;
      model_rx(b);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [7:0]  addr;
      axi.awvalid = 0; axi.awaddr = '0; axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.bready = 0;
      axi.arvalid = 0; axi.araddr = '0; axi.rready = 0;
      Status_In = 32'hCAFE_0001; Rx_Data = '0; Rx_Data_Valid = 1'b0;
      model_reset();

      repeat (3) tick();
      check("rst_awready", 32'(axi.awready), 32'd0);
      check("rst_wready", 32'(axi.wready), 32'd0);
      check("rst_arready", 32'(axi.arready), 32'd0);
      check("rst_bvalid", 32'(axi.bvalid), 32'd0);
      check("rst_rvalid", 32'(axi.rvalid), 32'd0);
      check("rst_ctrl", Ctrl_Reg, 32'd0);
      check("rst_tx", 32'({Tx_Data_Valid, Tx_Data}), 32'd0);
      check("rst_rdata", axi.rdata, 32'd0);
      AXI_Rstn = 1'b1;
      tick();
      check("post_rst_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);

      // 1: partial-strobe CTRL write
      do_write(8'h00, 32'hA5A5_1234, 4'b0011, 0, 0, 0, r);
      check("t1_ctrl", Ctrl_Reg, 32'h0000_1234);
      check("t1_bresp", 32'(r), 32'(RESP_OKAY));

      // 2: AW three cycles ahead of W
      do_write(8'h10, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, r);
      do_read(8'h10, 0, 1'b0, 8'h00, d, r);
      check("t2_scratch", d, 32'hDEAD_BEEF);

      // 3: TX mailbox
      do_write(8'h08, 32'h0000_0055, 4'h1, 0, 0, 0, r);
      check("t3_tx", 32'(Tx_Data), 32'h55);
      do_read(8'h08, 1, 1'b0, 8'h00, d, r);
      check("t3_tx_rd", d, 32'h0000_0055);

      // 4: RX overflow then clear on read
      rx_strobe(8'h3C);
      rx_strobe(8'h7E);
      do_read(8'h0C, 0, 1'b0, 8'h00, d, r);
      check("t4_rx_ovf", d, 32'h0000_037E);
      do_read(8'h0C, 0, 1'b0, 8'h00, d, r);
      check("t4_rx_clr", d, 32'h0000_007E);

      // 5: error responses and held B channel
      do_read(8'h1C, 0, 1'b0, 8'h00, d, r);
      check("t5_rresp", 32'(r), 32'(RESP_SLVERR));
      check("t5_rdata", d, 32'd0);
      do_write(8'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 5, r);
      check("t5_bresp", 32'(r), 32'(RESP_SLVERR));
      do_read(8'h04, 0, 1'b0, 8'h00, d, r);
      check("t5_status", d, 32'hCAFE_0001);

      // RX byte landing on the clearing read handshake
      rx_strobe(8'h11);
      rx_strobe(8'h22);
      do_read(8'h0C, 2, 1'b1, 8'h99, d, r);
      check("rx_same_cycle_old", d, 32'h0000_0322);
      do_read(8'h0C, 0, 1'b0, 8'h00, d, r);
      check("rx_same_cycle_new", d, 32'h0000_0199);

      for (int n = 0; n < 150; n++) begin
         addr = {($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b0,
                 3'($urandom_range(0, 7)), 2'($urandom)};
         case ($urandom_range(0, 3))
            0, 1: do_write(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), r);
            2: do_read(addr, $urandom_range(0, 3), 1'b0, 8'h00, d, r);
            default: begin
               if ($urandom_range(0, 1) == 1) rx_strobe(8'($urandom));
               else begin Status_In = $urandom; tick(); end
            end
         endcase
      end

      // 6: reset with B and R both pending
      axi.awaddr = 8'h00; axi.wdata = 32'hFFFF_FFFF; axi.wstrb = 4'hF; axi.araddr = 8'h14;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      tick();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      check("t6_b_pending", 32'(axi.bvalid), 32'd1);
      check("t6_r_pending", 32'(axi.rvalid), 32'd1);
      check("t6_ctrl_set", Ctrl_Reg, 32'hFFFF_FFFF);
      AXI_Rstn = 1'b0;
      tick();
      model_reset();
      check("t6_bvalid", 32'(axi.bvalid), 32'd0);
      check("t6_rvalid", 32'(axi.rvalid), 32'd0);
      check("t6_ctrl", Ctrl_Reg, 32'd0);
      check("t6_readies_rst", 32'({axi.awready, axi.wready, axi.arready}), 32'd0);
      AXI_Rstn = 1'b1;
      #1;
      check("t6_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
      tick();
      tick();
      check("t6_no_stale_resp", 32'({axi.bvalid, axi.rvalid}), 32'd0);
      do_read(8'h00, 0, 1'b0, 8'h00, d, r);
      do_read(8'h0C, 0, 1'b0, 8'h00, d, r);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
